// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation.
// State words are x0..x4, x0 in the most significant position.
package ascon_pkg;

  localparam int MAX_ROUNDS = 12;

  localparam int R0A = 19;
  localparam int R0B = 28;
  localparam int R1A = 61;
  localparam int R1B = 39;
  localparam int R2A = 1;
  localparam int R2B = 6;
  localparam int R3A = 10;
  localparam int R3B = 17;
  localparam int R4A = 7;
  localparam int R4B = 41;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          n
  );
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_iter_if.sv
// Start/busy/done handshake and state buses of the permutation core.
interface ascon_perm_iter_if;
  logic        start;
  logic [3:0]  rounds;
  logic [63:0] x0, x1, x2, x3, x4;
  logic        busy;
  logic        done;
  logic [63:0] y0, y1, y2, y3, y4;

  modport master (
    output start, rounds, x0, x1, x2, x3, x4,
    input  busy, done, y0, y1, y2, y3, y4
  );

  modport slave (
    input  start, rounds, x0, x1, x2, x3, x4,
    output busy, done, y0, y1, y2, y3, y4
  );
endinterface

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, bitsliced S-box, linear layer.
// A low enable passes the state through untouched.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     d,
  input  logic [3:0] idx,
  input  logic       en,
  output state_t     q
);

  state_t a, s, l;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  always_comb begin
    a    = d;
    a.x2 = d.x2 ^ {56'd0, rc(idx)};

    b0 = a.x0 ^ a.x4;
    b1 = a.x1;
    b2 = a.x2 ^ a.x1;
    b3 = a.x3;
    b4 = a.x4 ^ a.x3;

    c0 = b0 ^ (~b1 & b2);
    c1 = b1 ^ (~b2 & b3);
    c2 = b2 ^ (~b3 & b4);
    c3 = b3 ^ (~b4 & b0);
    c4 = b4 ^ (~b0 & b1);

    s.x0 = c0 ^ c4;
    s.x1 = c1 ^ c0;
    s.x2 = ~c2;
    s.x3 = c3 ^ c2;
    s.x4 = c4;

    l.x0 = s.x0 ^ ror(s.x0, R0A) ^ ror(s.x0, R0B);
    l.x1 = s.x1 ^ ror(s.x1, R1A) ^ ror(s.x1, R1B);
    l.x2 = s.x2 ^ ror(s.x2, R2A) ^ ror(s.x2, R2B);
    l.x3 = s.x3 ^ ror(s.x3, R3A) ^ ror(s.x3, R3B);
    l.x4 = s.x4 ^ ror(s.x4, R4A) ^ ror(s.x4, R4B);

    q = en ? l : d;
  end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation p^a, UNROLL rounds per clock.
// FSM, remaining-round counter, round-index base and state register.
module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic              clk,
  input logic              rst,
  ascon_perm_iter_if.slave bus
);

  localparam logic [3:0] UN   = 4'(UNROLL);
  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  fsm_t       state, state_n;
  state_t     st, st_n;
  logic [3:0] left, left_n;
  logic [3:0] base, base_n;
  logic       done, done_n;
  logic       accept;
  logic [3:0] nr, todo, n, cur_base;
  state_t     chain [UNROLL+1];

  assign accept   = bus.start && (state == IDLE);
  assign nr       = (bus.rounds > MAXR) ? MAXR : bus.rounds;
  // rounds outstanding before this cycle's batch
  assign todo     = accept ? nr : left;
  assign n        = (todo < UN) ? todo : UN;
  assign cur_base = accept ? (MAXR - nr) : base;
  assign chain[0] = accept ?
    {bus.x0, bus.x1, bus.x2, bus.x3, bus.x4} : st;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .d   (chain[g]),
      .idx (cur_base + 4'(g)),
      .en  (4'(g) < n),
      .q   (chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      left  <= '0;
      base  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      st    <= st_n;
      left  <= left_n;
      base  <= base_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && nr > UN) state_n = RUN;
      RUN:  if (left <= UN) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    st_n   = st;
    left_n = left;
    base_n = base;
    done_n = 1'b0;
    if (accept || state == RUN) begin
      st_n   = chain[UNROLL];
      left_n = todo - n;
      base_n = cur_base + n;
      done_n = (todo <= UN);
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done;
  assign bus.y0   = st.x0;
  assign bus.y1   = st.x1;
  assign bus.y2   = st.x2;
  assign bus.y3   = st.x3;
  assign bus.y4   = st.x4;

endmodule
